spike_spi_poller: RTL and testbench

- SPI master and scheduler that polls the SpikeDriver_SPI slave.
- Each frame: asserts lnss, shifts a read command out on lmosi, then clocks in a SZPFIRED-bit fired vector on lmiso.
- Presents the received vector in parallel with a one-cycle valid strobe.
- Frames are started one-shot by `start` or periodically by an internal frame timer; this block sits on the host/FPGA side of the SPI link and paces all traffic to the spike driver.

---
 rtl/spike_spi_poller.sv | 191 +++++++++++++++++++
 tb/tb_spike_spi_poller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_spi_poller.sv
// ============================================================================
// Module  : spike_spi_poller
// Brief   : SPI master / frame scheduler that polls the SpikeDriver_SPI slave
//           for its fired vector, one-shot or at a fixed auto-poll period.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_spi_poller #(
    parameter int              SZPFIRED = 32,
    parameter int              CMDW     = 8,
    parameter logic [CMDW-1:0] CMD_READ = 8'hA5,
    parameter int              CLKDIV   = 4,
    parameter int              PERIOD   = 50000
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic                start,
    input  logic                auto_en,
    input  logic                lmiso,
    output logic                lsck,
    output logic                lmosi,
    output logic                lnss,
    output logic [SZPFIRED-1:0] FOut,
    output logic                fired_valid,
    output logic                busy,
    output logic                overrun
);

    localparam int N    = CMDW + SZPFIRED;
    localparam int PW   = $clog2(CLKDIV);
    localparam int BW   = $clog2(N + 1);
    localparam int PERW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [PW-1:0]   c_PH_LAST  = PW'(CLKDIV - 1);
    localparam logic [BW-1:0]   c_NBITS    = BW'(N);
    localparam logic [BW-1:0]   c_CMDBITS  = BW'(CMDW);
    localparam logic [PERW-1:0] c_PER_LAST = PERW'(PERIOD - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4,
        S_GAP   = 3'd5
    } state_t;

    state_t              r_state;
    logic [PW-1:0]       r_phase;
    logic [BW-1:0]       r_bitcnt;
    logic [N-1:0]        r_shift;
    logic [PERW-1:0]     r_per;
    logic                r_lsck;
    logic                r_lmosi;
    logic                r_lnss;
    logic [SZPFIRED-1:0] r_fout;
    logic                r_fired_valid;
    logic                r_busy;
    logic                r_overrun;

    logic w_tick;
    logic w_trigger;

    assign w_tick    = auto_en && (r_per == c_PER_LAST);
    assign w_trigger = start || w_tick;

    // Free-running poll timer, held at zero whenever auto polling is off.
    always_ff @(posedge clk50) begin
        if (reset || !auto_en) begin
            r_per <= '0;
        end else if (r_per == c_PER_LAST) begin
            r_per <= '0;
        end else begin
            r_per <= r_per + PERW'(1);
        end
    end

    always_ff @(posedge clk50) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_phase       <= '0;
            r_bitcnt      <= '0;
            r_shift       <= '0;
            r_lsck        <= 1'b0;
            r_lmosi       <= 1'b0;
            r_lnss        <= 1'b1;
            r_fout        <= '0;
            r_fired_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_fired_valid <= 1'b0;
            if (w_tick && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_trigger) begin
                        r_state  <= S_SETUP;
                        r_phase  <= '0;
                        r_bitcnt <= '0;
                        r_shift  <= {CMD_READ, {SZPFIRED{1'b0}}};
                        r_busy   <= 1'b1;
                        r_lnss   <= 1'b0;
                        r_lsck   <= 1'b0;
                        r_lmosi  <= CMD_READ[CMDW-1];
                    end
                end

                S_SETUP: begin
                    if (r_phase == c_PH_LAST) begin
                        r_state <= S_HIGH;
                        r_phase <= '0;
                        r_lsck  <= 1'b1;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end

                S_HIGH: begin
                    if (r_phase == '0) begin
                        r_shift  <= {r_shift[N-2:0], lmiso};
                        r_bitcnt <= r_bitcnt + BW'(1);
                    end
                    // lmosi changes together with the falling lsck edge.
                    if (r_phase == c_PH_LAST) begin
                        r_state <= S_LOW;
                        r_phase <= '0;
                        r_lsck  <= 1'b0;
                        r_lmosi <= (r_bitcnt < c_CMDBITS) ? r_shift[N-1] : 1'b0;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end

                S_LOW: begin
                    if (r_phase == c_PH_LAST) begin
                        r_phase <= '0;
                        if (r_bitcnt < c_NBITS) begin
                            r_state <= S_HIGH;
                            r_lsck  <= 1'b1;
                        end else begin
                            r_state       <= S_DONE;
                            r_lnss        <= 1'b1;
                            r_lmosi       <= 1'b0;
                            r_fout        <= r_shift[SZPFIRED-1:0];
                            r_fired_valid <= 1'b1;
                        end
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end

                S_DONE: begin
                    r_state <= S_GAP;
                    r_phase <= '0;
                end

                S_GAP: begin
                    if (r_phase == c_PH_LAST) begin
                        r_state <= S_IDLE;
                        r_phase <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_phase <= r_phase + PW'(1);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_lnss  <= 1'b1;
                    r_lsck  <= 1'b0;
                end
            endcase
        end
    end

    assign lsck        = r_lsck;
    assign lmosi       = r_lmosi;
    assign lnss        = r_lnss;
    assign FOut        = r_fout;
    assign fired_valid = r_fired_valid;
    assign busy        = r_busy;
    assign overrun     = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_spike_spi_poller.sv
// ============================================================================
// Module  : tb_spike_spi_poller
// Brief   : Directed self-checking bench for spike_spi_poller with a mode-0
//           slave model answering each frame with a programmable fired vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spike_spi_poller;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        auto_en = 1'b0;
    logic        lmiso = 1'b0;
    logic        lsck, lmosi, lnss, fired_valid, busy, overrun;
    logic [31:0] FOut;

    logic        auto_en_s = 1'b0;
    logic        start_s, lmiso_s;
    logic        lsck_s, lmosi_s, lnss_s, fv_s, busy_s, ovr_s;
    logic [31:0] fout_s;

    assign start_s = 1'b0;
    assign lmiso_s = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk50 = ~clk50;

    spike_spi_poller #(.PERIOD(1000)) u_dut (
        .clk50(clk50), .reset(reset), .start(start), .auto_en(auto_en),
        .lmiso(lmiso), .lsck(lsck), .lmosi(lmosi), .lnss(lnss),
        .FOut(FOut), .fired_valid(fired_valid), .busy(busy), .overrun(overrun)
    );

    spike_spi_poller #(.PERIOD(200)) u_dut_s (
        .clk50(clk50), .reset(reset), .start(start_s), .auto_en(auto_en_s),
        .lmiso(lmiso_s), .lsck(lsck_s), .lmosi(lmosi_s), .lnss(lnss_s),
        .FOut(fout_s), .fired_valid(fv_s), .busy(busy_s), .overrun(ovr_s)
    );

    // Mode-0 slave: first bit presented when selected, next bit on each falling lsck.
    logic [31:0] slave_data = 32'h0;
    logic [39:0] sword = 40'h0;
    int          sidx = 0;
    bit          in_frame = 1'b0;
    always @(posedge lnss or negedge lnss or negedge lsck) begin
        if (lnss) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            in_frame = 1'b1;
            sidx     = 0;
            sword    = {8'hFF, slave_data};
        end else if (sidx < 39) begin
            sidx++;
        end
        lmiso = sword[39-sidx];
    end

    logic [39:0] mosi_cap = 40'h0;
    always @(posedge lsck) mosi_cap = {mosi_cap[38:0], lmosi};

    int fv_cnt = 0, nss_fall = 0, low_len = 0, last_low_len = 0;
    bit prev_lnss = 1'b1;
    always @(negedge clk50) begin
        if (fired_valid) fv_cnt++;
        if (prev_lnss && !lnss) nss_fall++;
        if (!lnss) low_len++;
        else if (!prev_lnss) begin
            last_low_len = low_len;
            low_len = 0;
        end
        prev_lnss = lnss;
    end

    task automatic do_reset;
        @(negedge clk50) reset = 1'b1;
        @(negedge clk50);
        @(negedge clk50) reset = 1'b0;
    endtask

    task automatic pulse_start;
        @(negedge clk50) start = 1'b1;
        @(negedge clk50) start = 1'b0;
    endtask

    task automatic wait_fv(input string tag);
        int c = 0;
        while (!fired_valid && c < 2000) begin
            @(negedge clk50);
            c++;
        end
        n_checks++;
        if (fired_valid !== 1'b1) $display("FAIL %s_timeout: fired_valid=%b after %0d cycles, required 1", tag, fired_valid, c);
        else n_pass++;
    endtask

    task automatic wait_idle;
        int c = 0;
        while (busy && c < 2000) begin
            @(negedge clk50);
            c++;
        end
    endtask

    task automatic test_reset;
        do_reset();
        @(negedge clk50);
        n_checks++;
        if ({lnss, lsck, lmosi, fired_valid, busy, overrun} !== 6'b100000)
            $display("FAIL reset_ctrl: {lnss,lsck,lmosi,fv,busy,ovr}=%b required 100000", {lnss, lsck, lmosi, fired_valid, busy, overrun});
        else n_pass++;
        n_checks++;
        if (FOut !== 32'h0) $display("FAIL reset_fout: FOut=%h required 00000000", FOut);
        else n_pass++;
    endtask

    task automatic test_single;
        int fv0, c;
        slave_data = 32'hDEADBEEF;
        fv0 = fv_cnt;
        pulse_start();
        wait_fv("single");
        n_checks++;
        if (FOut !== 32'hDEADBEEF) $display("FAIL single_fout: FOut=%h required deadbeef", FOut);
        else n_pass++;
        @(negedge clk50);
        n_checks++;
        if (fired_valid !== 1'b0) $display("FAIL single_fv_width: fired_valid=%b one cycle after DONE, required 0", fired_valid);
        else n_pass++;
        c = 0;
        while (busy && c < 20) begin
            c++;
            @(negedge clk50);
        end
        n_checks++;
        if (c !== 4) $display("FAIL single_gap: busy high %0d cycles after DONE, required 4", c);
        else n_pass++;
        n_checks++;
        if (last_low_len !== 324) $display("FAIL single_nss_len: lnss low %0d cycles, required 324", last_low_len);
        else n_pass++;
        n_checks++;
        if (mosi_cap !== {8'hA5, 32'h0}) $display("FAIL single_mosi: lmosi bits=%h required a500000000", mosi_cap);
        else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL single_fv_count: %0d pulses, required 1", fv_cnt - fv0);
        else n_pass++;
    endtask

    task automatic test_start_ignored;
        int fv0, nf0;
        slave_data = 32'h12345678;
        fv0 = fv_cnt;
        nf0 = nss_fall;
        pulse_start();
        repeat (8) @(negedge clk50);
        pulse_start();
        repeat (88) @(negedge clk50);
        pulse_start();
        wait_fv("ignored");
        wait_idle();
        repeat (400) @(negedge clk50);
        n_checks++;
        if (nss_fall - nf0 !== 1) $display("FAIL ignored_frames: %0d frames, required 1", nss_fall - nf0);
        else n_pass++;
        n_checks++;
        if (fv_cnt - fv0 !== 1) $display("FAIL ignored_fv: %0d pulses, required 1", fv_cnt - fv0);
        else n_pass++;
        n_checks++;
        if (FOut !== 32'h12345678) $display("FAIL ignored_fout: FOut=%h required 12345678", FOut);
        else n_pass++;
    endtask

    task automatic test_midreset;
        slave_data = 32'hCAFEF00D;
        pulse_start();
        repeat (149) @(negedge clk50);
        reset = 1'b1;
        @(negedge clk50);
        reset = 1'b0;
        n_checks++;
        if ({lnss, lsck, busy} !== 3'b100) $display("FAIL midreset_ctrl: {lnss,lsck,busy}=%b required 100", {lnss, lsck, busy});
        else n_pass++;
        n_checks++;
        if (FOut !== 32'h0) $display("FAIL midreset_fout: FOut=%h required 00000000", FOut);
        else n_pass++;
        slave_data = 32'hA5A55A5A;
        pulse_start();
        wait_fv("midreset");
        @(negedge clk50);
        n_checks++;
        if (last_low_len !== 324) $display("FAIL midreset_len: lnss low %0d cycles, required 324", last_low_len);
        else n_pass++;
        n_checks++;
        if (FOut !== 32'hA5A55A5A) $display("FAIL midreset_fout2: FOut=%h required a5a55a5a", FOut);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_auto;
        int c;
        do_reset();
        @(negedge clk50) auto_en = 1'b1;
        c = 0;
        while (lnss && c < 1500) begin
            @(negedge clk50);
            c++;
        end
        n_checks++;
        if (c !== 1000) $display("FAIL auto_first: first frame after %0d cycles, required 1000", c);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            c = 0;
            while (!lnss && c < 1500) begin
                @(negedge clk50);
                c++;
            end
            while (lnss && c < 1500) begin
                @(negedge clk50);
                c++;
            end
            n_checks++;
            if (c !== 1000) $display("FAIL auto_period%0d: frame spacing %0d cycles, required 1000", k, c);
            else n_pass++;
        end
        auto_en = 1'b0;
        wait_idle();
        n_checks++;
        if (overrun !== 1'b0) $display("FAIL auto_overrun: overrun=%b required 0", overrun);
        else n_pass++;
    endtask

    task automatic test_coincide;
        int fv0, nf0;
        do_reset();
        slave_data = 32'h00000001;
        fv0 = fv_cnt;
        nf0 = nss_fall;
        @(negedge clk50) auto_en = 1'b1;
        repeat (999) @(negedge clk50);
        start = 1'b1;
        @(negedge clk50);
        start = 1'b0;
        auto_en = 1'b0;
        wait_fv("coincide");
        wait_idle();
        repeat (20) @(negedge clk50);
        n_checks++;
        if (nss_fall - nf0 !== 1 || fv_cnt - fv0 !== 1)
            $display("FAIL coincide_single: frames=%0d pulses=%0d, required 1 and 1", nss_fall - nf0, fv_cnt - fv0);
        else n_pass++;
        n_checks++;
        if (FOut !== 32'h00000001) $display("FAIL coincide_lsb: FOut=%h required 00000001", FOut);
        else n_pass++;
        slave_data = 32'h80000000;
        pulse_start();
        wait_fv("msb");
        n_checks++;
        if (FOut !== 32'h80000000) $display("FAIL bitorder_msb: FOut=%h required 80000000", FOut);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_overrun;
        do_reset();
        @(negedge clk50) auto_en_s = 1'b1;
        repeat (300) @(negedge clk50);
        n_checks++;
        if (ovr_s !== 1'b0 || lnss_s !== 1'b0) $display("FAIL overrun_early: overrun=%b lnss=%b required 0 0", ovr_s, lnss_s);
        else n_pass++;
        repeat (150) @(negedge clk50);
        n_checks++;
        if (ovr_s !== 1'b1) $display("FAIL overrun_set: overrun=%b required 1", ovr_s);
        else n_pass++;
        auto_en_s = 1'b0;
        repeat (600) @(negedge clk50);
        n_checks++;
        if (ovr_s !== 1'b1 || busy_s !== 1'b0) $display("FAIL overrun_sticky: overrun=%b busy=%b required 1 0", ovr_s, busy_s);
        else n_pass++;
        do_reset();
        @(negedge clk50);
        n_checks++;
        if (ovr_s !== 1'b0) $display("FAIL overrun_clear: overrun=%b required 0", ovr_s);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_start_ignored();
        test_midreset();
        test_auto();
        test_coincide();
        test_overrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
